iot_event_encoder: RTL and testbench

Producer side of the Active IoT Devices Monitor control interface. Watches a vector of per-device link-status bits, turns every connect/disconnect edge into a queued event, and drains the queue as one `on_off`/`change` command per clock toward the up/down device counter. Per-direction pending counters buffer bursts; a shadow count mirrors the value the counter will show.

---
 rtl/iot_event_if.sv | 25 ++
 rtl/iot_event_encoder.sv | 113 +++++++++++
 tb/tb_iot_event_encoder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/iot_event_if.sv
// Status-in / command-out bundle between the link-status event encoder and its consumer.
// The encoder takes the master side; the counter or monitor takes the slave side.
interface iot_event_if #(
    parameter int N_DEV  = 8,
    parameter int PEND_W = 8
);
    logic [N_DEV-1:0]  dev_status;
    logic              on_off;
    logic              change;
    logic [7:0]        shadow_count;
    logic [PEND_W-1:0] pend_up;
    logic [PEND_W-1:0] pend_dn;
    logic              idle;
    logic              overflow;

    modport master (
        input  dev_status,
        output on_off, change, shadow_count, pend_up, pend_dn, idle, overflow
    );

    modport slave (
        output dev_status,
        input  on_off, change, shadow_count, pend_up, pend_dn, idle, overflow
    );
endinterface

// File: rtl/iot_event_encoder.sv
// Turns per-device connect/disconnect edges into queued up/down events and drains
// them as one on_off/change step per clock, with a shadow of the counter value.
module iot_event_encoder #(
    parameter int N_DEV  = 8,
    parameter int PEND_W = 8
) (
    input  logic clk,
    input  logic rst,
    iot_event_if.master bus
);
    localparam int CNT_W = $clog2(N_DEV + 1);
    localparam int SUM_W = PEND_W + CNT_W + 1;
    localparam logic [SUM_W-1:0] PEND_MAX = {{(CNT_W + 1){1'b0}}, {PEND_W{1'b1}}};

    logic [N_DEV-1:0]  prev_reg;
    logic [N_DEV-1:0]  rise_bits;
    logic [N_DEV-1:0]  fall_bits;
    logic [CNT_W-1:0]  n_up;
    logic [CNT_W-1:0]  n_dn;

    logic [PEND_W-1:0] pend_up_reg, pend_up_next;
    logic [PEND_W-1:0] pend_dn_reg, pend_dn_next;
    logic              last_dir_reg, last_dir_next;
    logic              on_off_reg, on_off_next;
    logic              change_reg, change_next;
    logic [7:0]        shadow_reg, shadow_next;
    logic              overflow_reg, overflow_next;

    logic              has_up, has_dn;
    logic              emit, emit_dir, emit_up, emit_dn;
    logic [SUM_W-1:0]  up_sum, dn_sum;
    logic              up_sat, dn_sat;

    generate
        for (genvar gi = 0; gi < N_DEV; gi++) begin : g_edge
            assign rise_bits[gi] =  bus.dev_status[gi] & ~prev_reg[gi];
            assign fall_bits[gi] = ~bus.dev_status[gi] &  prev_reg[gi];
        end
    endgenerate

    always_comb begin
        n_up = '0;
        n_dn = '0;
        for (int i = 0; i < N_DEV; i++) begin
            n_up = n_up + CNT_W'(rise_bits[i]);
            n_dn = n_dn + CNT_W'(fall_bits[i]);
        end
    end

    // When both directions are pending, alternate so neither queue starves.
    always_comb begin
        has_up   = |pend_up_reg;
        has_dn   = |pend_dn_reg;
        emit     = has_up | has_dn;
        emit_dir = (has_up & has_dn) ? ~last_dir_reg : has_up;
        emit_up  = emit &  emit_dir;
        emit_dn  = emit & ~emit_dir;
    end

    // Widened arithmetic so a burst on top of a nearly full counter is seen before clamping.
    always_comb begin
        up_sum = SUM_W'(pend_up_reg) + SUM_W'(n_up) - SUM_W'(emit_up);
        dn_sum = SUM_W'(pend_dn_reg) + SUM_W'(n_dn) - SUM_W'(emit_dn);
        up_sat = up_sum > PEND_MAX;
        dn_sat = dn_sum > PEND_MAX;

        pend_up_next  = up_sat ? {PEND_W{1'b1}} : up_sum[PEND_W-1:0];
        pend_dn_next  = dn_sat ? {PEND_W{1'b1}} : dn_sum[PEND_W-1:0];
        overflow_next = overflow_reg | up_sat | dn_sat;

        on_off_next   = emit;
        change_next   = emit ? emit_dir : 1'b1;
        last_dir_next = emit ? emit_dir : last_dir_reg;

        shadow_next = shadow_reg;
        if (emit_up) begin
            shadow_next = shadow_reg + 8'd1;
        end else if (emit_dn) begin
            shadow_next = shadow_reg - 8'd1;
        end
    end

    // prev clears on reset so devices still connected re-register as fresh connects.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg     <= '0;
            pend_up_reg  <= '0;
            pend_dn_reg  <= '0;
            last_dir_reg <= 1'b0;
            on_off_reg   <= 1'b0;
            change_reg   <= 1'b1;
            shadow_reg   <= 8'd0;
            overflow_reg <= 1'b0;
        end else begin
            prev_reg     <= bus.dev_status;
            pend_up_reg  <= pend_up_next;
            pend_dn_reg  <= pend_dn_next;
            last_dir_reg <= last_dir_next;
            on_off_reg   <= on_off_next;
            change_reg   <= change_next;
            shadow_reg   <= shadow_next;
            overflow_reg <= overflow_next;
        end
    end

    assign bus.on_off       = on_off_reg;
    assign bus.change       = change_reg;
    assign bus.shadow_count = shadow_reg;
    assign bus.pend_up      = pend_up_reg;
    assign bus.pend_dn      = pend_dn_reg;
    assign bus.idle         = ~(has_up | has_dn);
    assign bus.overflow     = overflow_reg;
endmodule

// File: tb/tb_iot_event_encoder.sv
// Bench for iot_event_encoder: a 16-device/8-bit instance and an 8-device/3-bit instance
// share one status bus and are both compared every cycle against an event-count model.
module tb_iot_event_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] status = 16'h0;

    int total = 0;
    int bad   = 0;

    iot_event_if #(.N_DEV(16), .PEND_W(8)) b1 ();
    iot_event_if #(.N_DEV(8),  .PEND_W(3)) b2 ();

    assign b1.dev_status = status;
    assign b2.dev_status = status[7:0];

    iot_event_encoder #(.N_DEV(16), .PEND_W(8)) u1 (.clk(clk), .rst(rst), .bus(b1.master));
    iot_event_encoder #(.N_DEV(8),  .PEND_W(3)) u2 (.clk(clk), .rst(rst), .bus(b2.master));

    always #5 clk = ~clk;

    // Model state per instance: queued events counted as plain integers.
    int          m_up   [2];
    int          m_dn   [2];
    int          m_last [2];
    int          m_sh   [2];
    int          m_ovf  [2];
    int          m_on   [2];
    int          m_chg  [2];
    logic [15:0] m_prev [2];
    int          m_max  [2] = '{255, 7};
    logic [15:0] m_mask [2] = '{16'hFFFF, 16'h00FF};

    task automatic check(input string tag, input logic [31:0] obs, input int expv);
        total++;
        assert (obs === 32'(expv)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_step(input int k, input logic r, input logic [15:0] s);
        logic [15:0] sv;
        int nup, ndn, emit, dir;
        if (r) begin
            m_up[k] = 0; m_dn[k] = 0; m_last[k] = 0; m_sh[k] = 0;
            m_ovf[k] = 0; m_on[k] = 0; m_chg[k] = 1; m_prev[k] = 16'h0;
            return;
        end
        sv  = s & m_mask[k];
        nup = $countones(sv & ~m_prev[k]);
        ndn = $countones(~sv & m_prev[k] & m_mask[k]);
        emit = (m_up[k] > 0 || m_dn[k] > 0) ? 1 : 0;
        if (m_up[k] > 0 && m_dn[k] > 0) dir = 1 - m_last[k];
        else                            dir = (m_up[k] > 0) ? 1 : 0;
        m_up[k] = m_up[k] + nup - ((emit == 1 && dir == 1) ? 1 : 0);
        m_dn[k] = m_dn[k] + ndn - ((emit == 1 && dir == 0) ? 1 : 0);
        if (m_up[k] > m_max[k]) begin m_up[k] = m_max[k]; m_ovf[k] = 1; end
        if (m_dn[k] > m_max[k]) begin m_dn[k] = m_max[k]; m_ovf[k] = 1; end
        m_on[k]  = emit;
        m_chg[k] = (emit == 1) ? dir : 1;
        if (emit == 1) begin
            m_last[k] = dir;
            m_sh[k]   = (m_sh[k] + ((dir == 1) ? 1 : 255)) % 256;
        end
        m_prev[k] = sv;
    endtask

    task automatic compare_all();
        check("u1.on_off",   b1.on_off,       m_on[0]);
        check("u1.change",   b1.change,       m_chg[0]);
        check("u1.shadow",   b1.shadow_count, m_sh[0]);
        check("u1.pend_up",  b1.pend_up,      m_up[0]);
        check("u1.pend_dn",  b1.pend_dn,      m_dn[0]);
        check("u1.idle",     b1.idle,         (m_up[0] == 0 && m_dn[0] == 0) ? 1 : 0);
        check("u1.overflow", b1.overflow,     m_ovf[0]);
        check("u2.on_off",   b2.on_off,       m_on[1]);
        check("u2.change",   b2.change,       m_chg[1]);
        check("u2.shadow",   b2.shadow_count, m_sh[1]);
        check("u2.pend_up",  b2.pend_up,      m_up[1]);
        check("u2.pend_dn",  b2.pend_dn,      m_dn[1]);
        check("u2.idle",     b2.idle,         (m_up[1] == 0 && m_dn[1] == 0) ? 1 : 0);
        check("u2.overflow", b2.overflow,     m_ovf[1]);
    endtask

    task automatic tick(input logic r, input logic [15:0] s);
        rst    = r;
        status = s;
        @(posedge clk);
        model_step(0, r, s);
        model_step(1, r, s);
        #1;
        $display("tick rst=%0b status=%04h | u1 on=%0b chg=%0b sh=%0d up=%0d dn=%0d | u2 on=%0b chg=%0b sh=%0d up=%0d dn=%0d ovf=%0b",
                 r, s, b1.on_off, b1.change, b1.shadow_count, b1.pend_up, b1.pend_dn,
                 b2.on_off, b2.change, b2.shadow_count, b2.pend_up, b2.pend_dn, b2.overflow);
        compare_all();
    endtask

    // Hold status until both queues are empty, bounded by a cycle budget.
    task automatic drain(input logic [15:0] s, input int limit);
        int n = 0;
        while (!(b1.idle === 1'b1 && b2.idle === 1'b1) && n < limit) begin
            tick(1'b0, s);
            n++;
        end
        check("drain_done", {30'd0, b2.idle, b1.idle}, 3);
    endtask

    initial begin
        logic [15:0] s;
        int chg_exp [4] = '{1, 0, 1, 0};

        // Reset with four devices already connected, then release.
        tick(1'b1, 16'h000F);
        check("rst_on_off",   b1.on_off, 0);
        check("rst_change",   b1.change, 1);
        check("rst_shadow",   b1.shadow_count, 0);
        check("rst_idle",     b1.idle, 1);
        check("rst_overflow", b1.overflow, 0);
        tick(1'b0, 16'h000F);
        check("t1_pend_up", b1.pend_up, 4);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 16'h000F);
            check("t1_on_off", b1.on_off, 1);
            check("t1_change", b1.change, 1);
        end
        check("t1_shadow", b1.shadow_count, 4);
        check("t1_idle",   b1.idle, 1);
        tick(1'b0, 16'h000F);
        check("t1_on_off_end", b1.on_off, 0);

        // Single disconnect.
        tick(1'b0, 16'h000E);
        check("t2_pend_dn", b1.pend_dn, 1);
        tick(1'b0, 16'h000E);
        check("t2_on_off",  b1.on_off, 1);
        check("t2_change",  b1.change, 0);
        check("t2_shadow",  b1.shadow_count, 3);

        // Two connects and two disconnects in one cycle: round-robin drain.
        tick(1'b0, 16'h0038);
        check("t3_pend_up", b1.pend_up, 2);
        check("t3_pend_dn", b1.pend_dn, 2);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 16'h0038);
            check("t3_on_off", b1.on_off, 1);
            check("t3_change", b1.change, chg_exp[i]);
        end
        check("t3_shadow", b1.shadow_count, 3);

        // One new connect per cycle for ten cycles.
        tick(1'b1, 16'h0000);
        tick(1'b0, 16'h0000);
        s = 16'h0;
        for (int i = 0; i < 10; i++) begin
            s[i] = 1'b1;
            tick(1'b0, s);
            if (i >= 1) begin
                check("t4_pend_up", b1.pend_up, 1);
                check("t4_on_off",  b1.on_off, 1);
            end
        end
        tick(1'b0, s);
        check("t4_on_off_last", b1.on_off, 1);
        check("t4_shadow",      b1.shadow_count, 10);

        // Saturation on the 3-bit instance.
        tick(1'b1, 16'h0000);
        tick(1'b0, 16'h00FF);
        check("t5_pend_up_a", b2.pend_up, 7);
        check("t5_overflow",  b2.overflow, 1);
        tick(1'b0, 16'h0000);
        tick(1'b0, 16'h00FF);
        check("t5_pend_up_b", b2.pend_up, 7);
        check("t5_wide_ovf",  b1.overflow, 0);
        drain(16'h00FF, 200);
        check("t5_ovf_sticky", b2.overflow, 1);
        tick(1'b1, 16'h00FF);
        check("t5_ovf_clear", b2.overflow, 0);

        // Shadow wrap both ways: one connect lost to saturation leaves net -1.
        tick(1'b1, 16'h0000);
        tick(1'b0, 16'h00FF);
        drain(16'h00FF, 50);
        check("t6_shadow_7", b2.shadow_count, 7);
        tick(1'b0, 16'h00F0);
        tick(1'b0, 16'h0000);
        drain(16'h0000, 50);
        check("t6_shadow_255", b2.shadow_count, 255);
        tick(1'b0, 16'h0001);
        drain(16'h0001, 50);
        check("t6_shadow_0", b2.shadow_count, 0);

        // Reset in the middle of a drain.
        tick(1'b1, 16'h0000);
        tick(1'b0, 16'h00FF);
        for (int i = 0; i < 5; i++) tick(1'b0, 16'h00FF);
        check("t7_pend_up_3", b1.pend_up, 3);
        tick(1'b1, 16'h00FF);
        check("t7_on_off", b1.on_off, 0);
        check("t7_pend_up", b1.pend_up, 0);
        check("t7_shadow", b1.shadow_count, 0);

        // Randomized traffic: sparse toggles, occasional dense bursts and resets.
        s = 16'h00FF;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) s = s ^ 16'($urandom);
            else                           s = s ^ 16'($urandom & $urandom & $urandom);
            tick(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0, s);
        end
        drain(s, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
